// File: rtl/calc_engine.sv
// calc_engine: BCD-entry four-function calculator with serial shift-add multiply.
// Define CALC_DIV_EN to build the restoring divider (op_code 5); otherwise DIV is ignored.
module calc_engine #(
  parameter int NDIG = 4,
  parameter int AW   = 28
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4*NDIG-1:0] dig_in,
  input  logic              op_valid,
  input  logic [2:0]        op_code,
  output logic              op_ready,
  output logic              busy,
  output logic              cal_done,
  output logic [AW-1:0]     cal_ans,
  output logic [1:0]        cal_err
);

  localparam logic [2:0] OP_ENTER = 3'd1;
  localparam logic [2:0] OP_PLUS  = 3'd2;
  localparam logic [2:0] OP_MINUS = 3'd3;
  localparam logic [2:0] OP_MULT  = 3'd4;
  localparam logic [2:0] OP_DIV   = 3'd5;
  localparam logic [2:0] OP_ESC   = 3'd6;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_DIV0 = 2'd1;
  localparam logic [1:0] ERR_OVF  = 2'd2;
  localparam logic [1:0] ERR_BCD  = 2'd3;

  localparam int CW = $clog2(AW + 1);
  localparam logic [CW-1:0] CONV_LAST = CW'(NDIG - 1);
  localparam logic [CW-1:0] EXEC_LAST = CW'(AW - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV_A,
    S_WAIT,
    S_CONV_B,
    S_EXEC,
    S_OUTP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [2:0]        r_op;
  logic [4*NDIG-1:0] r_shift;
  logic [AW-1:0]     r_acc;
  logic              r_bad;
  logic [CW-1:0]     r_cnt;
  logic [AW-1:0]     r_a;
  logic [AW-1:0]     r_b;
  logic [AW-1:0]     r_hi;
  logic [AW-1:0]     r_lo;
  logic [AW-1:0]     r_ans;
  logic [1:0]        r_err;
  logic              r_done;

  logic              w_accept;
  logic              w_isArith;
  logic              w_isEnter;
  logic              w_isEsc;
  logic              w_divCode;
  logic              w_serialOp;
  logic [3:0]        w_digit;
  logic              w_badNow;
  logic [AW-1:0]     w_convNext;
  logic              w_convLast;
  logic              w_execLast;
  logic [AW:0]       w_sum;
  logic [AW:0]       w_mulSum;

`ifdef CALC_DIV_EN
  logic [AW:0]       w_remSh;
  logic              w_divGe;
  logic [AW-1:0]     w_divDiff;

  assign w_divCode  = (op_code == OP_DIV);
  assign w_serialOp = (r_op == OP_MULT) || (r_op == OP_DIV);
  assign w_remSh    = {r_hi, r_lo[AW-1]};
  assign w_divGe    = (w_remSh >= {1'b0, r_b});
  assign w_divDiff  = w_remSh[AW-1:0] - r_b;
`else
  assign w_divCode  = 1'b0;
  assign w_serialOp = (r_op == OP_MULT);
`endif

  assign op_ready = (r_state == S_IDLE) || (r_state == S_WAIT) || (r_state == S_OUTP);
  assign busy     = (r_state == S_CONV_A) || (r_state == S_CONV_B) || (r_state == S_EXEC);
  assign cal_done = r_done;
  assign cal_ans  = r_ans;
  assign cal_err  = r_err;

  assign w_accept  = op_valid && op_ready;
  assign w_isArith = (op_code == OP_PLUS) || (op_code == OP_MINUS) ||
                     (op_code == OP_MULT) || w_divCode;
  assign w_isEnter = (op_code == OP_ENTER);
  assign w_isEsc   = (op_code == OP_ESC);

  // Horner step on the most significant remaining digit; a bad digit is sticky.
  assign w_digit    = r_shift[4*NDIG-1 -: 4];
  assign w_badNow   = r_bad || (w_digit > 4'd9);
  assign w_convNext = (r_acc << 3) + (r_acc << 1) + {{(AW-4){1'b0}}, w_digit};
  assign w_convLast = (r_cnt == CONV_LAST);
  assign w_execLast = !w_serialOp || (r_cnt == EXEC_LAST);

  assign w_sum    = {1'b0, r_a} + {1'b0, r_b};
  assign w_mulSum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : {(AW+1){1'b0}});

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && (w_isArith || w_isEnter)) begin
          w_next = S_CONV_A;
        end
      end
      S_CONV_A: begin
        if (w_convLast) begin
          w_next = (w_badNow || (r_op == OP_ENTER)) ? S_OUTP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_accept && w_isEnter) begin
          w_next = S_CONV_B;
        end else if (w_accept && w_isEsc) begin
          w_next = S_IDLE;
        end
      end
      S_CONV_B: begin
        if (w_convLast) begin
          w_next = w_badNow ? S_OUTP : S_EXEC;
        end
      end
      S_EXEC: begin
        if (w_execLast) begin
          w_next = S_OUTP;
        end
      end
      S_OUTP: begin
        if (w_accept && w_isArith) begin
          w_next = S_WAIT;
        end else if (w_accept && w_isEsc) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: conversion, operand capture, serial execute and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op    <= '0;
      r_shift <= '0;
      r_acc   <= '0;
      r_bad   <= 1'b0;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_ans   <= '0;
      r_err   <= ERR_NONE;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_isEsc) begin
            r_ans <= '0;
            r_err <= ERR_NONE;
          end else if (w_accept && (w_isArith || w_isEnter)) begin
            r_op    <= op_code;
            r_shift <= dig_in;
            r_acc   <= '0;
            r_bad   <= 1'b0;
            r_cnt   <= '0;
            r_err   <= ERR_NONE;
          end
        end
        S_CONV_A, S_CONV_B: begin
          r_acc   <= w_convNext;
          r_shift <= r_shift << 4;
          r_bad   <= w_badNow;
          r_cnt   <= r_cnt + CW'(1);
          if (w_convLast) begin
            if (w_badNow) begin
              r_ans  <= '0;
              r_err  <= ERR_BCD;
              r_done <= 1'b1;
            end else if (r_state == S_CONV_A) begin
              if (r_op == OP_ENTER) begin
                r_ans  <= w_convNext;
                r_done <= 1'b1;
              end else begin
                r_a <= w_convNext;
              end
            end else begin
              r_b   <= w_convNext;
              r_cnt <= '0;
              r_hi  <= '0;
              r_lo  <= (r_op == OP_MULT) ? w_convNext : r_a;
            end
          end
        end
        S_WAIT: begin
          if (w_accept && w_isEsc) begin
            r_ans <= '0;
            r_err <= ERR_NONE;
          end else if (w_accept && w_isArith) begin
            r_op  <= op_code;
            r_err <= ERR_NONE;
          end else if (w_accept && w_isEnter) begin
            r_shift <= dig_in;
            r_acc   <= '0;
            r_bad   <= 1'b0;
            r_cnt   <= '0;
            r_err   <= ERR_NONE;
          end
        end
        S_EXEC: begin
          r_cnt <= r_cnt + CW'(1);
          case (r_op)
            OP_PLUS: begin
              r_done <= 1'b1;
              if (w_sum[AW]) begin
                r_ans <= '0;
                r_err <= ERR_OVF;
              end else begin
                r_ans <= w_sum[AW-1:0];
              end
            end
            OP_MINUS: begin
              r_done <= 1'b1;
              if (r_b > r_a) begin
                r_ans <= '0;
                r_err <= ERR_OVF;
              end else begin
                r_ans <= r_a - r_b;
              end
            end
            // Product accumulates in {r_hi, r_lo}; any bit left in r_hi means >= 2^AW.
            OP_MULT: begin
              r_hi <= w_mulSum[AW:1];
              r_lo <= {w_mulSum[0], r_lo[AW-1:1]};
              if (w_execLast) begin
                r_done <= 1'b1;
                if (w_mulSum[AW:1] != '0) begin
                  r_ans <= '0;
                  r_err <= ERR_OVF;
                end else begin
                  r_ans <= {w_mulSum[0], r_lo[AW-1:1]};
                end
              end
            end
`ifdef CALC_DIV_EN
            OP_DIV: begin
              r_hi <= w_divGe ? w_divDiff : w_remSh[AW-1:0];
              r_lo <= {r_lo[AW-2:0], w_divGe};
              if (w_execLast) begin
                r_done <= 1'b1;
                if (r_b == '0) begin
                  r_ans <= '0;
                  r_err <= ERR_DIV0;
                end else begin
                  r_ans <= {r_lo[AW-2:0], w_divGe};
                end
              end
            end
`endif
            default: ;
          endcase
        end
        S_OUTP: begin
          if (w_accept && w_isEsc) begin
            r_ans <= '0;
            r_err <= ERR_NONE;
          end else if (w_accept && w_isArith) begin
            r_a   <= r_ans;
            r_op  <= op_code;
            r_err <= ERR_NONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_engine.sv
// tb_calc_engine: directed-vector bench for calc_engine (NDIG=4, AW=28).
// Hand-computed answers, error codes and cal_done latencies are checked per operation.
module tb_calc_engine;

  localparam int NDIG = 4;
  localparam int AW   = 28;

  localparam logic [2:0] OP_ENTER = 3'd1;
  localparam logic [2:0] OP_PLUS  = 3'd2;
  localparam logic [2:0] OP_MINUS = 3'd3;
  localparam logic [2:0] OP_MULT  = 3'd4;
  localparam logic [2:0] OP_DIV   = 3'd5;
  localparam logic [2:0] OP_ESC   = 3'd6;

  logic              clk;
  logic              reset;
  logic [4*NDIG-1:0] dig_in;
  logic              op_valid;
  logic [2:0]        op_code;
  logic              op_ready;
  logic              busy;
  logic              cal_done;
  logic [AW-1:0]     cal_ans;
  logic [1:0]        cal_err;

  int passCount;
  int checkCount;

  calc_engine #(
    .NDIG(NDIG),
    .AW  (AW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .dig_in  (dig_in),
    .op_valid(op_valid),
    .op_code (op_code),
    .op_ready(op_ready),
    .busy    (busy),
    .cal_done(cal_done),
    .cal_ans (cal_ans),
    .cal_err (cal_err)
  );

  // 10 ns free-running clock; the bench samples on the falling edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts one comparison and reports it when the observed value differs.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Waits (bounded) for op_ready, then presents one operation for a single cycle.
  // Returns just after the accepting rising edge.
  task automatic applyStimulus(input logic [2:0] code, input logic [15:0] digits);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!op_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!op_ready) checkOutput("readyWait", {31'd0, op_ready}, 32'd1);
    op_valid = 1'b1;
    op_code  = code;
    dig_in   = digits;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    op_code  = 3'd0;
  endtask

  // Counts falling edges after the accepting edge until cal_done; 0 means it never came.
  task automatic waitDone(output int latency);
    int cycles;
    bit seen;
    latency = 0;
    cycles  = 0;
    seen    = 1'b0;
    while (!seen && cycles < 200) begin
      @(negedge clk);
      cycles++;
      if (cal_done) begin
        seen    = 1'b1;
        latency = cycles;
      end
    end
  endtask

  // Waits for a result and checks its latency, answer and error code.
  task automatic checkResult(input string tag, input int expLat,
                             input logic [31:0] expAns, input logic [31:0] expErr);
    int lat;
    waitDone(lat);
    checkOutput({tag, "_lat"}, lat, expLat);
    checkOutput({tag, "_ans"}, {4'd0, cal_ans}, expAns);
    checkOutput({tag, "_err"}, {30'd0, cal_err}, expErr);
  endtask

  initial begin
    int pulses;
    passCount  = 0;
    checkCount = 0;
    reset      = 1'b1;
    op_valid   = 1'b0;
    op_code    = 3'd0;
    dig_in     = '0;

    // Reset state while reset is held.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready", {31'd0, op_ready}, 32'd1);
    checkOutput("rst_busy",  {31'd0, busy},     32'd0);
    checkOutput("rst_done",  {31'd0, cal_done}, 32'd0);
    checkOutput("rst_ans",   {4'd0, cal_ans},   32'd0);
    checkOutput("rst_err",   {30'd0, cal_err},  32'd0);
    reset = 1'b0;

    // 1234 + 766 = 2000, done six cycles after ENTER.
    applyStimulus(OP_PLUS, 16'h1234);
    applyStimulus(OP_ENTER, 16'h0766);
    checkResult("add", 6, 2000, 0);

    // ESC from OUTP clears the answer.
    applyStimulus(OP_ESC, 16'h0000);
    @(negedge clk);
    checkOutput("esc_ans", {4'd0, cal_ans}, 32'd0);

    // 9999 * 9999 = 99980001 after the AW-cycle multiply.
    applyStimulus(OP_MULT, 16'h9999);
    applyStimulus(OP_ENTER, 16'h9999);
    checkResult("mul", 33, 99980001, 0);

    // Chained multiply overflows 2^28.
    applyStimulus(OP_MULT, 16'h0000);
    applyStimulus(OP_ENTER, 16'h9999);
    checkResult("mulOvf", 33, 0, 2);

    // 5 - 7 underflows; ESC then clears the error.
    applyStimulus(OP_ESC, 16'h0000);
    applyStimulus(OP_MINUS, 16'h0005);
    applyStimulus(OP_ENTER, 16'h0007);
    checkResult("subUnf", 6, 0, 2);
    applyStimulus(OP_ESC, 16'h0000);
    @(negedge clk);
    checkOutput("escErr",   {30'd0, cal_err},  32'd0);
    checkOutput("escReady", {31'd0, op_ready}, 32'd1);
    checkOutput("escBusy",  {31'd0, busy},     32'd0);

    // ENTER from IDLE loads the converted value directly (NDIG+1 latency).
    applyStimulus(OP_ENTER, 16'h0042);
    checkResult("idleEnter", 5, 42, 0);

    // ENTER in OUTP is ignored.
    applyStimulus(OP_ENTER, 16'h0001);
    @(negedge clk);
    checkOutput("outpEnterBusy", {31'd0, busy}, 32'd0);
    checkOutput("outpEnterAns",  {4'd0, cal_ans}, 32'd42);

    // Chained add uses the held answer as operand A.
    applyStimulus(OP_PLUS, 16'h9999);
    applyStimulus(OP_ENTER, 16'h0008);
    checkResult("chainAdd", 6, 50, 0);

`ifdef CALC_DIV_EN
    // 1000 / 0 reports divide-by-zero; 1000 / 7 = 142.
    applyStimulus(OP_ESC, 16'h0000);
    applyStimulus(OP_DIV, 16'h1000);
    applyStimulus(OP_ENTER, 16'h0000);
    checkResult("div0", 33, 0, 1);
    applyStimulus(OP_ESC, 16'h0000);
    applyStimulus(OP_DIV, 16'h1000);
    applyStimulus(OP_ENTER, 16'h0007);
    checkResult("div", 33, 142, 0);
`else
    // DIV is ignored in IDLE and in WAIT.
    applyStimulus(OP_ESC, 16'h0000);
    applyStimulus(OP_DIV, 16'h1000);
    @(negedge clk);
    checkOutput("divIdleReady", {31'd0, op_ready}, 32'd1);
    checkOutput("divIdleBusy",  {31'd0, busy},     32'd0);
    applyStimulus(OP_ENTER, 16'h0003);
    checkResult("divIdleEnter", 5, 3, 0);
    applyStimulus(OP_ESC, 16'h0000);
    applyStimulus(OP_PLUS, 16'h0010);
    applyStimulus(OP_DIV, 16'h0002);
    @(negedge clk);
    checkOutput("divWaitReady", {31'd0, op_ready}, 32'd1);
    applyStimulus(OP_ENTER, 16'h0005);
    checkResult("divWaitAdd", 6, 15, 0);
`endif

    // Invalid BCD digit: error 3, answer 0, a single done pulse; error holds until next op.
    applyStimulus(OP_ESC, 16'h0000);
    applyStimulus(OP_ENTER, 16'h12A4);
    checkResult("bcd", 5, 0, 3);
    @(negedge clk);
    checkOutput("bcdOnePulse", {31'd0, cal_done}, 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("bcdHold", {30'd0, cal_err}, 32'd3);
    applyStimulus(OP_PLUS, 16'h0000);
    @(negedge clk);
    checkOutput("bcdClear", {30'd0, cal_err}, 32'd0);

    // Reset during MULT EXEC aborts without a done pulse; op_valid while busy is ignored.
    applyStimulus(OP_ESC, 16'h0000);
    applyStimulus(OP_ENTER, 16'h0077);
    checkResult("preMul", 5, 77, 0);
    applyStimulus(OP_MULT, 16'h0000);
    applyStimulus(OP_ENTER, 16'h0002);
    repeat (8) @(negedge clk);
    checkOutput("execBusy", {31'd0, busy}, 32'd1);
    op_valid = 1'b1;
    op_code  = OP_ESC;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    op_code  = 3'd0;
    @(negedge clk);
    checkOutput("busyIgnoreBusy", {31'd0, busy}, 32'd1);
    checkOutput("busyIgnoreAns",  {4'd0, cal_ans}, 32'd77);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("abortReady", {31'd0, op_ready}, 32'd1);
    checkOutput("abortBusy",  {31'd0, busy},     32'd0);
    checkOutput("abortAns",   {4'd0, cal_ans},   32'd0);
    checkOutput("abortErr",   {30'd0, cal_err},  32'd0);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (cal_done) pulses++;
    end
    checkOutput("abortNoDone", pulses, 0);
    applyStimulus(OP_ENTER, 16'h0005);
    checkResult("postAbort", 5, 5, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
